// File: rtl/rx_digit_display_pkg.sv
// Shared constants for the received-digit display: ASCII codes, blank digit, 7-segment patterns
// and the byte classifier used by the decode stage.
package rx_digit_display_pkg;

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_ESC = 8'h1B;

    localparam logic [3:0]  DIG_BLANK = 4'hF;
    localparam logic [15:0] BUF_BLANK = {4{DIG_BLANK}};

    // Active-high {dp,g,f,e,d,c,b,a}; dp is never lit.
    localparam logic [7:0] SEG_OFF = 8'h00;
    localparam logic [7:0] SEG_0   = 8'h3F;
    localparam logic [7:0] SEG_1   = 8'h06;
    localparam logic [7:0] SEG_2   = 8'h5B;
    localparam logic [7:0] SEG_3   = 8'h4F;
    localparam logic [7:0] SEG_4   = 8'h66;
    localparam logic [7:0] SEG_5   = 8'h6D;
    localparam logic [7:0] SEG_6   = 8'h7D;
    localparam logic [7:0] SEG_7   = 8'h07;
    localparam logic [7:0] SEG_8   = 8'h7F;
    localparam logic [7:0] SEG_9   = 8'h6F;

    typedef enum logic [1:0] {
        BYTE_DIGIT,
        BYTE_BS,
        BYTE_ESC,
        BYTE_OTHER
    } byte_kind_e;

    function automatic byte_kind_e classify_byte(input logic [7:0] b);
        if (b >= ASCII_0 && b <= ASCII_9) return BYTE_DIGIT;
        if (b == ASCII_BS)                return BYTE_BS;
        if (b == ASCII_ESC)               return BYTE_ESC;
        return BYTE_OTHER;
    endfunction

endpackage

// File: rtl/rx_digit_display_seg7_bcd_enc.sv
// Combinational BCD to active-high 7-segment encoder; codes A..F (including blank) light nothing.
module seg7_bcd_enc
    import rx_digit_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/rx_digit_display.sv
// Collects received ASCII digits into a 4-digit shift buffer (with backspace/escape editing)
// and scans the buffer onto a 4-digit multiplexed 7-segment display.
module rx_digit_display
    import rx_digit_display_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        clear,
    output logic [7:0]  seg,
    output logic [3:0]  dig_sel,
    output logic [15:0] digits_bcd,
    output logic        err_pulse
);

    localparam int TICK_MAX = CLK_HZ / SCAN_HZ - 1;
    localparam int TICK_W   = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAX);

    function automatic logic [7:0] pol_seg(input logic [7:0] s);
        return SEG_ACT_LOW ? ~s : s;
    endfunction

    function automatic logic [3:0] pol_dig(input logic [3:0] d);
        return SEG_ACT_LOW ? ~d : d;
    endfunction

    byte_kind_e        kind;
    logic [15:0]       digits_p0;
    logic              err_p0;
    logic [TICK_W-1:0] tick_cnt;
    logic [1:0]        idx;
    logic [3:0]        cur_digit;
    logic [7:0]        seg_hi;
    logic [7:0]        seg_p1;
    logic [3:0]        dig_sel_p1;

    assign kind = classify_byte(rx_data);

    // Stage p0: byte decode into the digit buffer; clear wins over a same-cycle byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_p0 <= BUF_BLANK;
            err_p0    <= 1'b0;
        end else begin
            err_p0 <= 1'b0;
            if (clear) begin
                digits_p0 <= BUF_BLANK;
            end else if (rx_valid) begin
                case (kind)
                    BYTE_DIGIT: digits_p0 <= {digits_p0[11:0], rx_data[3:0]};
                    BYTE_BS:    digits_p0 <= {DIG_BLANK, digits_p0[15:4]};
                    BYTE_ESC:   digits_p0 <= BUF_BLANK;
                    default:    err_p0    <= 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            idx      <= 2'd0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign cur_digit = digits_p0[{idx, 2'b00} +: 4];

    seg7_bcd_enc u_enc (
        .bcd (cur_digit),
        .seg (seg_hi)
    );

    // Stage p1: registered display drive, polarity applied here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p1     <= pol_seg(SEG_OFF);
            dig_sel_p1 <= pol_dig(4'b0001);
        end else begin
            seg_p1     <= pol_seg(seg_hi);
            dig_sel_p1 <= pol_dig(4'b0001 << idx);
        end
    end

    assign seg        = seg_p1;
    assign dig_sel    = dig_sel_p1;
    assign digits_bcd = digits_p0;
    assign err_pulse  = err_p0;

endmodule

// File: tb/tb_rx_digit_display.sv
// Directed plus randomized bench for rx_digit_display with a queue-based reference model.
module tb_rx_digit_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clear = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  dig_sel;
    logic [15:0] digits_bcd;
    logic        err_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: q holds {d3,d2,d1,d0} front to back, 15 = blank; k = clock edges since reset release.
    int q[$];
    int k;

    rx_digit_display #(
        .CLK_HZ      (1000),
        .SCAN_HZ     (100),
        .SEG_ACT_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .clear      (clear),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .digits_bcd (digits_bcd),
        .err_pulse  (err_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_pack();
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) r = {r[11:0], 4'(q[i])};
        return r;
    endfunction

    function automatic logic [7:0] seg_for(input int d);
        logic [7:0] hi;
        case (d)
            0: hi = 8'h3F;  1: hi = 8'h06;  2: hi = 8'h5B;  3: hi = 8'h4F;
            4: hi = 8'h66;  5: hi = 8'h6D;  6: hi = 8'h7D;  7: hi = 8'h07;
            8: hi = 8'h7F;  9: hi = 8'h6F;
            default: hi = 8'h00;
        endcase
        return ~hi;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic model_blank();
        q = '{15, 15, 15, 15};
    endtask

    // One clock: drive inputs at the falling edge, model the rising edge, check 1 time unit later.
    task automatic step(input bit v, input logic [7:0] b, input bit c);
        logic [15:0] prev;
        int          idx_prev;
        bit          err_exp;
        rx_valid = v;
        rx_data  = b;
        clear    = c;
        @(posedge clk);
        prev     = model_pack();
        idx_prev = (k / 10) % 4;
        k++;
        err_exp  = 1'b0;
        if (c) begin
            model_blank();
        end else if (v) begin
            if (b >= 8'h30 && b <= 8'h39) begin
                void'(q.pop_front());
                q.push_back(int'(b) - 48);
            end else if (b == 8'h08) begin
                void'(q.pop_back());
                q.push_front(15);
            end else if (b == 8'h1B) begin
                model_blank();
            end else begin
                err_exp = 1'b1;
            end
        end
        #1;
        chk("digits_bcd", digits_bcd, model_pack());
        chk("err_pulse", {15'd0, err_pulse}, {15'd0, err_exp});
        chk("seg", {8'd0, seg}, {8'd0, seg_for(int'((prev >> (4 * idx_prev)) & 16'hF))});
        chk("dig_sel", {12'd0, dig_sel}, {12'd0, ~(4'b0001 << idx_prev)});
        @(negedge clk);
        rx_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_digits"}, digits_bcd, 16'hFFFF);
        chk({tag, "_seg"}, {8'd0, seg}, 16'h00FF);
        chk({tag, "_dig_sel"}, {12'd0, dig_sel}, 16'h000E);
        chk({tag, "_err"}, {15'd0, err_pulse}, 16'h0000);
    endtask

    initial begin
        logic [7:0] b;
        int         r;

        model_blank();
        k = 0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Scan walks idx 0..3 and back to 0 over 50 idle clocks.
        idle(50);

        // Five digits: the first one falls off the top.
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h32, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h34, 1'b0);
        step(1'b1, 8'h35, 1'b0);
        chk("shift5", digits_bcd, 16'h2345);

        step(1'b1, 8'h08, 1'b0);
        chk("backspace", digits_bcd, 16'hF234);
        step(1'b1, 8'h1B, 1'b0);
        chk("escape", digits_bcd, 16'hFFFF);

        step(1'b1, 8'h32, 1'b0);
        step(1'b1, 8'h41, 1'b0);
        chk("bad_err", {15'd0, err_pulse}, 16'h0001);
        chk("bad_keep", digits_bcd, 16'hFFF2);
        idle(1);
        chk("bad_err_once", {15'd0, err_pulse}, 16'h0000);

        step(1'b1, 8'h37, 1'b1);
        chk("clear_wins", digits_bcd, 16'hFFFF);
        chk("clear_no_err", {15'd0, err_pulse}, 16'h0000);

        step(1'b1, 8'h30, 1'b0);
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h32, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        for (int i = 0; i < 44; i++) begin
            idle(1);
            case (dig_sel)
                4'b1110: chk("frame_d0", {8'd0, seg}, 16'h00B0);
                4'b1101: chk("frame_d1", {8'd0, seg}, 16'h00A4);
                4'b1011: chk("frame_d2", {8'd0, seg}, 16'h00F9);
                4'b0111: chk("frame_d3", {8'd0, seg}, 16'h00C0);
                default: chk("frame_sel", {12'd0, dig_sel}, 16'h000E);
            endcase
        end

        // Random byte stream, including back-to-back strobes and occasional clears.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5)      b = 8'h30 + 8'($urandom_range(0, 9));
            else if (r == 6) b = 8'h08;
            else if (r == 7) b = 8'h1B;
            else             b = 8'($urandom_range(0, 255));
            step(1'($urandom_range(0, 2) != 0), b, $urandom_range(0, 19) == 0);
        end

        // Reset in the middle of a frame with a non-blank buffer.
        step(1'b1, 8'h39, 1'b0);
        step(1'b1, 8'h38, 1'b0);
        idle(13);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        chk_reset_outputs("midreset_hold");
        rst_n = 1'b1;
        model_blank();
        k = 0;
        idle(25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
